// File: rtl/parking_pkg.sv
// parking_pkg: lane FSM states and synchronised sensor codes {a,b}.
package parking_pkg;
  typedef enum logic [2:0] {IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, WAIT_CLR} lane_state_t;
  localparam logic [1:0] S_NONE = 2'b00;
  localparam logic [1:0] S_A = 2'b10;
  localparam logic [1:0] S_AB = 2'b11;
  localparam logic [1:0] S_B = 2'b01;
endpackage

// File: rtl/parking_occupancy_counter_if.sv
// parking_occupancy_counter_if: sensor inputs, clear and occupancy outputs.
interface parking_occupancy_counter_if #(parameter int LANES = 2, parameter int CNT_W = 7);
  logic [LANES-1:0] a, b, lane_fault;
  logic clr, full, empty, ovf_err, unf_err;
  logic [CNT_W-1:0] count, free;
  modport master(output a, b, clr, input count, free, full, empty, ovf_err, unf_err, lane_fault);
  modport slave(input a, b, clr, output count, free, full, empty, ovf_err, unf_err, lane_fault);
endinterface

// File: rtl/park_lane_fsm.sv
// park_lane_fsm: sensor synchroniser and car direction decoder for one lane.
module park_lane_fsm
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic entry,
  output logic exit,
  output logic fault
);
  logic [1:0] a_q, b_q, s;
  lane_state_t state, nxt;
  logic entry_d, exit_d, fault_d;
  assign s = {a_q[1], b_q[1]};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      state <= IDLE;
      entry <= 1'b0;
      exit <= 1'b0;
      fault <= 1'b0;
    end else begin
      a_q <= {a_q[0], a};
      b_q <= {b_q[0], b};
      state <= nxt;
      entry <= entry_d;
      exit <= exit_d;
      fault <= fault_d;
    end
  // every state has its own sensor code which holds it; a jump over a phase faults
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = s == S_A ? IN_A : s == S_B ? OUT_B : s == S_AB ? WAIT_CLR : IDLE;
      IN_A:   nxt = s == S_AB ? IN_AB : s == S_NONE ? IDLE : s == S_B ? WAIT_CLR : IN_A;
      IN_AB:  nxt = s == S_B ? IN_B : s == S_A ? IN_A : s == S_NONE ? WAIT_CLR : IN_AB;
      IN_B:   nxt = s == S_NONE ? IDLE : s == S_AB ? IN_AB : s == S_A ? WAIT_CLR : IN_B;
      OUT_B:  nxt = s == S_AB ? OUT_AB : s == S_NONE ? IDLE : s == S_A ? WAIT_CLR : OUT_B;
      OUT_AB: nxt = s == S_A ? OUT_A : s == S_B ? OUT_B : s == S_NONE ? WAIT_CLR : OUT_AB;
      OUT_A:  nxt = s == S_NONE ? IDLE : s == S_AB ? OUT_AB : s == S_B ? WAIT_CLR : OUT_A;
      default: nxt = s == S_NONE ? IDLE : WAIT_CLR;
    endcase
  end
  always_comb begin
    entry_d = state == IN_B && s == S_NONE;
    exit_d = state == OUT_A && s == S_NONE;
    fault_d = state != WAIT_CLR && nxt == WAIT_CLR;
  end
endmodule

// File: rtl/parking_occupancy_counter.sv
// parking_occupancy_counter: per-lane direction decode feeding a saturating
// occupancy count with full/empty and sticky over/underflow flags.
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CAPACITY = 99,
  parameter int CNT_W = $clog2(CAPACITY + 1)
) (
  input logic clk,
  input logic reset,
  parking_occupancy_counter_if.slave bus
);
  localparam int W = CNT_W + 4;
  localparam logic signed [W-1:0] CAP = W'(CAPACITY);
  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);
  logic [LANES-1:0] entry, exit;
  logic signed [W-1:0] net, sum;
  logic [CNT_W-1:0] nxt, c;
  logic hi, lo;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    park_lane_fsm u_lane (
      .clk(clk), .reset(reset), .a(bus.a[i]), .b(bus.b[i]),
      .entry(entry[i]), .exit(exit[i]), .fault(bus.lane_fault[i])
    );
  end
  always_comb begin
    net = '0;
    for (int k = 0; k < LANES; k++) net = net + W'(entry[k]) - W'(exit[k]);
    sum = W'(bus.count) + net;
    hi = sum > CAP;
    lo = sum[W-1];
    nxt = hi ? CAP_C : lo ? '0 : sum[CNT_W-1:0];
    c = bus.clr ? '0 : nxt;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.count <= '0;
      bus.free <= CAP_C;
      bus.full <= 1'b0;
      bus.empty <= 1'b1;
      bus.ovf_err <= 1'b0;
      bus.unf_err <= 1'b0;
    end else begin
      bus.count <= c;
      bus.free <= CAP_C - c;
      bus.full <= c == CAP_C;
      bus.empty <= c == '0;
      bus.ovf_err <= !bus.clr && (bus.ovf_err || hi);
      bus.unf_err <= !bus.clr && (bus.unf_err || lo);
    end
endmodule

// File: tb/tb_parking_occupancy_counter.sv
// tb_parking_occupancy_counter: table vectors, timing/fault/reset sequences and
// random car passages checked against an arithmetic occupancy model.
module tb_parking_occupancy_counter;
  localparam int LANES = 2;
  localparam int CAP = 3;
  localparam int CW = 2;
  localparam int NONE = 0, ENT = 1, EXT = 2, BIN = 3, BOUT = 4, WENT = 5, WEXT = 6;
  typedef logic [1:0] ph_q[$];
  typedef struct {bit clr; int k0; int k1; int cnt; bit ovf; bit unf;} vec_t;
  logic clk = 0;
  logic reset = 1;
  int total = 0;
  int passed = 0;
  int m_cnt;
  bit m_ovf, m_unf;
  vec_t tbl[15];
  parking_occupancy_counter_if #(.LANES(LANES), .CNT_W(CW)) bus ();
  parking_occupancy_counter #(.LANES(LANES), .CAPACITY(CAP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask
  task automatic chk_state(input string nm, input int c, input bit o, input bit u);
    chk({nm, " count"}, 32'(bus.count), c);
    chk({nm, " free"}, 32'(bus.free), CAP - c);
    chk({nm, " full"}, 32'(bus.full), 32'(c == CAP));
    chk({nm, " empty"}, 32'(bus.empty), 32'(c == 0));
    chk({nm, " ovf_err"}, 32'(bus.ovf_err), 32'(o));
    chk({nm, " unf_err"}, 32'(bus.unf_err), 32'(u));
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_lane(input int l, input logic [1:0] v);
    bus.a[l] = v[1];
    bus.b[l] = v[0];
  endtask
  function automatic ph_q seq_of(input int k);
    case (k)
      ENT: return '{2'b10, 2'b11, 2'b01, 2'b00};
      EXT: return '{2'b01, 2'b11, 2'b10, 2'b00};
      BIN: return '{2'b10, 2'b00};
      BOUT: return '{2'b01, 2'b00};
      WENT: return '{2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00};
      WEXT: return '{2'b01, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00};
      default: return '{2'b00};
    endcase
  endfunction
  // sequences are front-padded with 00 so both lanes finish on the same cycle
  task automatic drive_pair(input int k0, input int k1, input int hold);
    ph_q s0, s1;
    s0 = seq_of(k0);
    s1 = seq_of(k1);
    while (s0.size() < s1.size()) s0.push_front(2'b00);
    while (s1.size() < s0.size()) s1.push_front(2'b00);
    foreach (s0[i]) begin
      set_lane(0, s0[i]);
      set_lane(1, s1[i]);
      tick(hold);
    end
    tick(5);
  endtask
  task automatic pulse_clr();
    bus.clr = 1;
    tick(1);
    bus.clr = 0;
  endtask
  function automatic int ins(input int k);
    return (k == ENT || k == WENT) ? 1 : 0;
  endfunction
  function automatic int outs(input int k);
    return (k == EXT || k == WEXT) ? 1 : 0;
  endfunction
  task automatic model_apply(input int k0, input int k1);
    int s;
    s = m_cnt + ins(k0) + ins(k1) - outs(k0) - outs(k1);
    if (s > CAP) begin m_cnt = CAP; m_ovf = 1; end
    else if (s < 0) begin m_cnt = 0; m_unf = 1; end
    else m_cnt = s;
  endtask
  initial begin
    tbl = '{
      '{0, NONE, EXT, 0, 0, 0}, '{0, NONE, EXT, 0, 0, 1}, '{1, NONE, NONE, 0, 0, 0},
      '{0, ENT, NONE, 1, 0, 0}, '{0, NONE, ENT, 2, 0, 0}, '{0, WENT, NONE, 3, 0, 0},
      '{0, ENT, EXT, 3, 0, 0}, '{0, ENT, NONE, 3, 1, 0}, '{1, NONE, NONE, 0, 0, 0},
      '{0, ENT, NONE, 1, 0, 0}, '{0, ENT, ENT, 3, 0, 0}, '{0, BIN, BOUT, 3, 0, 0},
      '{0, EXT, WEXT, 1, 0, 0}, '{0, EXT, EXT, 0, 0, 1}, '{1, NONE, NONE, 0, 0, 0}
    };
    bus.a = '0;
    bus.b = '0;
    bus.clr = 0;
    tick(2);
    chk_state("reset", 0, 0, 0);
    chk("reset lane_fault", 32'(bus.lane_fault), 0);
    reset = 0;
    tick(2);
    set_lane(0, 2'b10); tick(4);
    set_lane(0, 2'b11); tick(4);
    set_lane(0, 2'b01); tick(4);
    set_lane(0, 2'b00);
    tick(1); chk("lat k count", 32'(bus.count), 0);
    tick(1); chk("lat k+1 count", 32'(bus.count), 0);
    tick(1); chk("lat k+2 count", 32'(bus.count), 0);
    tick(1); chk_state("lat k+3", 1, 0, 0);
    tick(3);
    foreach (tbl[i]) begin
      if (tbl[i].clr) pulse_clr();
      drive_pair(tbl[i].k0, tbl[i].k1, 3);
      chk_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].ovf, tbl[i].unf);
    end
    set_lane(0, 2'b11);
    tick(1); chk("fault k", 32'(bus.lane_fault), 0);
    tick(1); chk("fault k+1", 32'(bus.lane_fault), 0);
    tick(1); chk("fault k+2", 32'(bus.lane_fault), 1);
    tick(1); chk("fault k+3", 32'(bus.lane_fault), 0);
    set_lane(0, 2'b01); tick(4);
    set_lane(0, 2'b00); tick(8);
    chk_state("fault ignore", 0, 0, 0);
    drive_pair(ENT, ENT, 3);
    chk_state("pre reset", 2, 0, 0);
    set_lane(0, 2'b10); tick(3);
    set_lane(0, 2'b11); tick(3);
    #2 reset = 1;
    #1 chk_state("mid reset", 0, 0, 0);
    chk("mid reset lane_fault", 32'(bus.lane_fault), 0);
    tick(2);
    reset = 0;
    set_lane(0, 2'b01); tick(4);
    set_lane(0, 2'b00); tick(8);
    chk_state("after reset", 0, 0, 0);
    m_cnt = 0;
    m_ovf = 0;
    m_unf = 0;
    for (int n = 0; n < 40; n++) begin
      int k0, k1;
      k0 = $urandom_range(6);
      k1 = $urandom_range(6);
      if ($urandom_range(7) == 0) begin
        pulse_clr();
        m_cnt = 0;
        m_ovf = 0;
        m_unf = 0;
      end
      drive_pair(k0, k1, $urandom_range(4, 2));
      model_apply(k0, k1);
      chk_state($sformatf("rand%0d", n), m_cnt, m_ovf, m_unf);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/parking_occupancy_counter.md
# parking_occupancy_counter

Multi-lane occupancy counter for the parking-meter sensor path. Each lane has an outer sensor a and an inner sensor b. The block synchronises each pair and decodes car direction with a per-lane FSM. It then accumulates all lanes into a single saturating occupancy count with full/empty and error flags. It replaces the single-lane entry/exit counter and feeds the display and billing logic.

## Interface
- LANES, 2: number of sensor lanes, 1..8
- CAPACITY, 99: maximum occupancy, ≥1
- CNT_W, $clog2(CAPACITY+1): width of the count and free outputs
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- a  in  LANES  outer sensor per lane, 1 = beam blocked, asynchronous
- b  in  LANES  inner sensor per lane, 1 = beam blocked, asynchronous
- clr  in  1  synchronous clear of count and sticky flags
- count  out  CNT_W  current occupancy
- free  out  CNT_W  CAPACITY − count
- full  out  1  count == CAPACITY
- empty  out  1  count == 0
- ovf_err  out  1  sticky: an entry was dropped because of saturation at CAPACITY
- unf_err  out  1  sticky: an exit was dropped because of saturation at 0
- lane_fault  out  LANES  one-cycle pulse per lane on an illegal sensor transition

## Operation
- Synchroniser: two flops per sensor bit. Reset value 0.
- Lane FSM operates on the synchronised pair {a,b}. States: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, WAIT_CLR.
- When the input is unchanged, the FSM holds its state in every state.
- IDLE transitions:
  - 10 → IN_A
  - 01 → OUT_B
  - 11 → WAIT_CLR, with a fault pulse
- IN_A transitions:
  - 11 → IN_AB
  - 00 → IDLE (car backed out; no event)
  - 01 → WAIT_CLR, with a fault pulse
- IN_AB transitions:
  - 01 → IN_B
  - 10 → IN_A
  - 00 → WAIT_CLR, with a fault pulse
- IN_B transitions:
  - 00 → IDLE, with an entry pulse
  - 11 → IN_AB
  - 10 → WAIT_CLR, with a fault pulse
- The OUT_* states mirror the IN_* states with a and b swapped. OUT_A on 00 → IDLE with an exit pulse.
- WAIT_CLR: 00 → IDLE; every other input holds the state. No event is generated from WAIT_CLR.
- Entry, exit and fault pulses are registered outputs of the FSM, one cycle wide.
- Accumulator: each cycle, net = popcount(entry) − popcount(exit), computed signed at CNT_W+4 bits.
- next = count + net, clamped to [0, CAPACITY].
- ovf_err is set if count + net > CAPACITY. unf_err is set if count + net < 0.
- Simultaneous entries and exits on different lanes net out before clamping. Example: count = CAPACITY with one entry and one exit gives no change and no error.
- clr has priority over events arriving in the same cycle. It sets count to 0 and clears both sticky flags. The FSMs are not affected.
- reset: count = 0, free = CAPACITY, full = 0, empty = 1, ovf_err = unf_err = 0, lane_fault = 0, all FSMs in IDLE. Reset asserted in the middle of a sequence discards the partial sequence.

## Timing
- A sensor change stable before clk edge k appears at the synchroniser output after edge k+1.
- The FSM pulse is high in the cycle after edge k+2.
- count, free, full and empty update at edge k+3. Latency from the final sensor transition to the count change is 3 cycles.
- full, empty and free are registered together with count; they are never combinational from the inputs.
- Sticky flags are set at the same edge as the clamped count update.
- clr takes effect at the next edge; count = 0 in the following cycle.
- Minimum sensor phase width is 1 cycle after synchronisation. Shorter glitches may be missed, and that is acceptable.

## Structure
- Shared package `parking_pkg` holds:
  - the lane state enum (IDLE … WAIT_CLR)
  - the sensor encoding constants S_NONE = 00, S_A = 10, S_AB = 11, S_B = 01
- Sub-module `park_lane_fsm`: synchroniser plus direction FSM for one lane. Ports: clk, reset, a, b, entry, exit, fault. It is instantiated LANES times in a generate loop.
- The top level holds the popcount, the signed adder, the clamp and the flag registers.

## Test plan
All scenarios use LANES = 2 and CAPACITY = 3.
- Lane 0 entry sequence 00,10,11,01,00 with 4 cycles per phase → count goes 0→1 exactly 3 cycles after the final 00; free = 2; empty goes 0.
- Lane 1 exit sequence at count = 1 → count = 0, empty = 1. A further exit → count stays 0, unf_err = 1 until clr.
- Four entries spread across lanes → count = 3, full = 1 after the third. The fourth entry sets ovf_err = 1 and count stays 3.
- Simultaneous lane 0 entry and lane 1 exit at count = 3 → count = 3 and no flag set. Two simultaneous entries at count = 1 → count = 3.
- Lane 0 sequence 00,10,00 (car backs out) → no event. Sequence 00,11 → lane_fault[0] pulse of 1 cycle; the lane then ignores input until 00.
- Reset asserted mid-sequence (after 10,11) with count = 2 → all outputs return to their reset values immediately. Completing the old sequence afterwards produces no event.
